// File: rtl/jtag_tap_pkg.sv
// Shared TAP definitions: 1149.1 state encoding, instruction codes, DR select
// and the TAP next-state function.
package jtag_tap_pkg;

    typedef enum logic [3:0] {
        TAP_EX2DR = 4'h0,
        TAP_EX1DR = 4'h1,
        TAP_SHDR  = 4'h2,
        TAP_PAUDR = 4'h3,
        TAP_SELIR = 4'h4,
        TAP_UPDDR = 4'h5,
        TAP_CAPDR = 4'h6,
        TAP_SELDR = 4'h7,
        TAP_EX2IR = 4'h8,
        TAP_EX1IR = 4'h9,
        TAP_SHIR  = 4'hA,
        TAP_PAUIR = 4'hB,
        TAP_RTI   = 4'hC,
        TAP_UPDIR = 4'hD,
        TAP_CAPIR = 4'hE,
        TAP_TLR   = 4'hF
    } tap_state_e;

    typedef enum logic [1:0] {
        DR_IDCODE = 2'd0,
        DR_USER   = 2'd1,
        DR_BYPASS = 2'd2
    } dr_sel_e;

    localparam logic [3:0] IR_IDCODE = 4'h1;
    localparam logic [3:0] IR_USER   = 4'h8;
    localparam logic [3:0] IR_BYPASS = 4'hF;

    localparam int unsigned IDCODE_WIDTH = 32;

    function automatic tap_state_e tap_next(input tap_state_e state, input logic tms);
        tap_state_e nxt;
        case (state)
            TAP_TLR:   nxt = tms ? TAP_TLR   : TAP_RTI;
            TAP_RTI:   nxt = tms ? TAP_SELDR : TAP_RTI;
            TAP_SELDR: nxt = tms ? TAP_SELIR : TAP_CAPDR;
            TAP_CAPDR: nxt = tms ? TAP_EX1DR : TAP_SHDR;
            TAP_SHDR:  nxt = tms ? TAP_EX1DR : TAP_SHDR;
            TAP_EX1DR: nxt = tms ? TAP_UPDDR : TAP_PAUDR;
            TAP_PAUDR: nxt = tms ? TAP_EX2DR : TAP_PAUDR;
            TAP_EX2DR: nxt = tms ? TAP_UPDDR : TAP_SHDR;
            TAP_UPDDR: nxt = tms ? TAP_SELDR : TAP_RTI;
            TAP_SELIR: nxt = tms ? TAP_TLR   : TAP_CAPIR;
            TAP_CAPIR: nxt = tms ? TAP_EX1IR : TAP_SHIR;
            TAP_SHIR:  nxt = tms ? TAP_EX1IR : TAP_SHIR;
            TAP_EX1IR: nxt = tms ? TAP_UPDIR : TAP_PAUIR;
            TAP_PAUIR: nxt = tms ? TAP_EX2IR : TAP_PAUIR;
            TAP_EX2IR: nxt = tms ? TAP_UPDIR : TAP_SHIR;
            TAP_UPDIR: nxt = tms ? TAP_SELDR : TAP_RTI;
            default:   nxt = TAP_TLR;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// TAP controller state register; advances on a detected TCK rise, forced to
// Test-Logic-Reset by trst or system reset.
module jtag_tap_fsm
    import jtag_tap_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rise,
    input  logic       trst,
    input  logic       tms,
    output tap_state_e state
);

    tap_state_e state_r;

    // State register: trst overrides a coincident TCK rise
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= TAP_TLR;
        end else if (trst) begin
            state_r <= TAP_TLR;
        end else if (rise) begin
            state_r <= tap_next(state_r, tms);
        end else begin
            state_r <= state_r;
        end
    end

    assign state = state_r;

endmodule

// File: rtl/jtag_tap_responder.sv
// JTAG TAP target in the system clock domain: TCK is oversampled as data,
// with IDCODE, BYPASS and one USER data register behind a shared TDO.
module jtag_tap_responder
    import jtag_tap_pkg::*;
#(
    parameter int unsigned IR_WIDTH   = 4,
    parameter logic [31:0] IDCODE_VAL = 32'h1000_0001,
    parameter int unsigned USER_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  enable_i,
    input  logic                  jtag_tck_i,
    input  logic                  jtag_tms_i,
    input  logic                  jtag_tdi_i,
    input  logic                  jtag_trst_i,
    output logic                  jtag_tdo_o,
    input  logic [USER_WIDTH-1:0] user_data_i,
    output logic [USER_WIDTH-1:0] user_data_o,
    output logic                  user_update_o,
    output logic [3:0]            tap_state_o
);

    localparam logic [IR_WIDTH-1:0] IR_IDCODE_W  = IR_WIDTH'(IR_IDCODE);
    localparam logic [IR_WIDTH-1:0] IR_USER_W    = IR_WIDTH'(IR_USER);
    localparam logic [IR_WIDTH-1:0] IR_BYPASS_W  = IR_WIDTH'(IR_BYPASS);
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE_W = IR_WIDTH'(2'b01);

    logic                    tck_q_r;
    logic                    rise_s;
    logic                    fall_s;
    logic                    rise_act_s;
    logic                    fall_act_s;
    tap_state_e              state_s;
    dr_sel_e                 dr_sel_s;
    logic                    tdo_next_s;

    logic [IR_WIDTH-1:0]     ir_r;
    logic [IR_WIDTH-1:0]     shift_ir_r;
    logic [IDCODE_WIDTH-1:0] dr_id_r;
    logic                    dr_byp_r;
    logic [USER_WIDTH-1:0]   dr_user_r;
    logic [USER_WIDTH-1:0]   user_shift_s;

    logic                    tdo_r;
    logic [USER_WIDTH-1:0]   user_data_r;
    logic                    user_update_r;

    assign rise_s = jtag_tck_i & ~tck_q_r & enable_i;
    assign fall_s = ~jtag_tck_i & tck_q_r & enable_i;
    // A TCK edge coinciding with trst is discarded entirely
    assign rise_act_s = rise_s & ~jtag_trst_i;
    assign fall_act_s = fall_s & ~jtag_trst_i;

    // Previous TCK sample; tracks even while disabled so re-enabling makes no false edge
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            tck_q_r <= 1'b0;
        end else begin
            tck_q_r <= jtag_tck_i;
        end
    end

    jtag_tap_fsm u_fsm (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .rise  (rise_s),
        .trst  (jtag_trst_i),
        .tms   (jtag_tms_i),
        .state (state_s)
    );

    // Instruction decode; anything not IDCODE or USER falls back to BYPASS
    always_comb begin
        dr_sel_s = DR_BYPASS;
        if (ir_r == IR_IDCODE_W) begin
            dr_sel_s = DR_IDCODE;
        end else if (ir_r == IR_USER_W) begin
            dr_sel_s = DR_USER;
        end else if (ir_r == IR_BYPASS_W) begin
            dr_sel_s = DR_BYPASS;
        end else begin
            dr_sel_s = DR_BYPASS;
        end
    end

    generate
        if (USER_WIDTH > 1) begin : g_user_shift
            assign user_shift_s = {jtag_tdi_i, dr_user_r[USER_WIDTH-1:1]};
        end else begin : g_user_bit
            assign user_shift_s = jtag_tdi_i;
        end
    endgenerate

    // Instruction register and its shift stage
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ir_r       <= IR_IDCODE_W;
            shift_ir_r <= {IR_WIDTH{1'b0}};
        end else begin
            if (jtag_trst_i || (state_s == TAP_TLR)) begin
                ir_r <= IR_IDCODE_W;
            end else if (fall_act_s && (state_s == TAP_UPDIR)) begin
                ir_r <= shift_ir_r;
            end else begin
                ir_r <= ir_r;
            end

            if (rise_act_s && (state_s == TAP_CAPIR)) begin
                shift_ir_r <= IR_CAPTURE_W;
            end else if (rise_act_s && (state_s == TAP_SHIR)) begin
                shift_ir_r <= {jtag_tdi_i, shift_ir_r[IR_WIDTH-1:1]};
            end else begin
                shift_ir_r <= shift_ir_r;
            end
        end
    end

    // Data registers: capture and shift only touch the one selected by ir
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            dr_id_r   <= {IDCODE_WIDTH{1'b0}};
            dr_byp_r  <= 1'b0;
            dr_user_r <= {USER_WIDTH{1'b0}};
        end else if (rise_act_s && (state_s == TAP_CAPDR)) begin
            case (dr_sel_s)
                DR_IDCODE: dr_id_r   <= IDCODE_VAL;
                DR_USER:   dr_user_r <= user_data_i;
                default:   dr_byp_r  <= 1'b0;
            endcase
        end else if (rise_act_s && (state_s == TAP_SHDR)) begin
            case (dr_sel_s)
                DR_IDCODE: dr_id_r   <= {jtag_tdi_i, dr_id_r[IDCODE_WIDTH-1:1]};
                DR_USER:   dr_user_r <= user_shift_s;
                default:   dr_byp_r  <= jtag_tdi_i;
            endcase
        end else begin
            dr_id_r   <= dr_id_r;
            dr_byp_r  <= dr_byp_r;
            dr_user_r <= dr_user_r;
        end
    end

    // TDO source: LSB of whichever register is being shifted, else 0
    always_comb begin
        tdo_next_s = 1'b0;
        if (state_s == TAP_SHIR) begin
            tdo_next_s = shift_ir_r[0];
        end else if (state_s == TAP_SHDR) begin
            case (dr_sel_s)
                DR_IDCODE: tdo_next_s = dr_id_r[0];
                DR_USER:   tdo_next_s = dr_user_r[0];
                default:   tdo_next_s = dr_byp_r;
            endcase
        end else begin
            tdo_next_s = 1'b0;
        end
    end

    // Falling-edge outputs: TDO launch and USER update with its one-cycle strobe
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            tdo_r         <= 1'b0;
            user_data_r   <= {USER_WIDTH{1'b0}};
            user_update_r <= 1'b0;
        end else begin
            if (fall_act_s) begin
                tdo_r <= tdo_next_s;
            end else begin
                tdo_r <= tdo_r;
            end

            if (fall_act_s && (state_s == TAP_UPDDR) && (dr_sel_s == DR_USER)) begin
                user_data_r   <= dr_user_r;
                user_update_r <= 1'b1;
            end else begin
                user_data_r   <= user_data_r;
                user_update_r <= 1'b0;
            end
        end
    end

    assign jtag_tdo_o    = tdo_r;
    assign user_data_o   = user_data_r;
    assign user_update_o = user_update_r;
    assign tap_state_o   = state_s;

endmodule

// File: tb/tb_jtag_tap_responder.sv
// Directed bench for jtag_tap_responder: a TCK-level reference model is
// compared every clk, plus literal checks of scanned-out streams.
module tb_jtag_tap_responder;

    logic        clk = 1'b0;
    logic        rst_n, en, tck, tms, tdi, trst;
    logic [31:0] user_in;
    logic        tdo;
    logic [31:0] user_out;
    logic        user_upd;
    logic [3:0]  tap_state;

    int tests = 0;
    int fails = 0;
    int pulses = 0;
    bit chk_on = 1'b0;

    // Reference model state
    int          m_state;
    logic [3:0]  m_ir, m_irsh;
    logic [63:0] m_dr;
    int          m_len;
    logic        m_tdo, m_upd, m_tck_prev;
    logic [31:0] m_udata;

    // IEEE 1149.1 transition table indexed by state code, for TMS=0 / TMS=1
    int next0 [16] = '{2, 3, 2, 3, 14, 12, 2, 6, 10, 11, 10, 11, 12, 12, 10, 12};
    int next1 [16] = '{5, 5, 1, 0, 15, 7, 1, 4, 13, 13, 9, 8, 7, 7, 9, 15};

    always #5 clk = ~clk;

    jtag_tap_responder #(
        .IR_WIDTH   (4),
        .IDCODE_VAL (32'h1000_0001),
        .USER_WIDTH (32)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .enable_i      (en),
        .jtag_tck_i    (tck),
        .jtag_tms_i    (tms),
        .jtag_tdi_i    (tdi),
        .jtag_trst_i   (trst),
        .jtag_tdo_o    (tdo),
        .user_data_i   (user_in),
        .user_data_o   (user_out),
        .user_update_o (user_upd),
        .tap_state_o   (tap_state)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic rise, fall;
        int   cur;
        rise = tck && !m_tck_prev && en;
        fall = !tck && m_tck_prev && en;
        m_tck_prev = tck;
        m_upd = 1'b0;
        if (!rst_n) begin
            m_state = 15; m_ir = 4'h1; m_irsh = 4'h0; m_dr = 64'd0; m_len = 1;
            m_tdo = 1'b0; m_udata = 32'd0; m_tck_prev = 1'b0;
        end else if (trst) begin
            m_state = 15; m_ir = 4'h1;
        end else begin
            cur = m_state;
            if (rise) begin
                if (cur == 14) m_irsh = 4'h1;
                if (cur == 10) m_irsh = {tdi, m_irsh[3:1]};
                if (cur == 6) begin
                    if (m_ir == 4'h1)      begin m_dr = 64'h1000_0001; m_len = 32; end
                    else if (m_ir == 4'h8) begin m_dr = {32'd0, user_in};  m_len = 32; end
                    else                   begin m_dr = 64'd0;          m_len = 1;  end
                end
                if (cur == 2) begin
                    m_dr = m_dr >> 1;
                    m_dr[m_len-1] = tdi;
                end
                m_state = tms ? next1[cur] : next0[cur];
                if (m_state == 15) m_ir = 4'h1;
            end
            if (fall) begin
                m_tdo = (cur == 10) ? m_irsh[0] : (cur == 2) ? m_dr[0] : 1'b0;
                if (cur == 13) m_ir = m_irsh;
                if (cur == 5 && m_ir == 4'h8) begin
                    m_udata = m_dr[31:0];
                    m_upd = 1'b1;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    // One TCK period as the bit-bang driver produces it; returns sampled TDO
    task automatic jclk(input logic tms_v, input logic tdi_v, output logic tdo_v);
        tms = tms_v; tdi = tdi_v;
        tck = 1'b1; tick(); tick();
        tck = 1'b0; tick(); tick();
        tdo_v = tdo;
    endtask

    // Full IR or DR scan from RTI back to RTI, bits LSB first
    task automatic scan(input bit is_ir, input int n, input logic [63:0] din, output logic [63:0] dout);
        logic t;
        dout = 64'd0;
        jclk(1'b1, 1'b0, t);
        if (is_ir) jclk(1'b1, 1'b0, t);
        jclk(1'b0, 1'b0, t);
        jclk(1'b0, 1'b0, t);
        dout[0] = t;
        for (int i = 0; i < n; i++) begin
            jclk((i == n - 1), din[i], t);
            if (i < n - 1) dout[i+1] = t;
        end
        jclk(1'b1, 1'b0, t);
        jclk(1'b0, 1'b0, t);
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_on) begin
            check("tap_state", 64'(tap_state), 64'(m_state[3:0]));
            check("tdo", 64'(tdo), 64'(m_tdo));
            check("user_data", 64'(user_out), 64'(m_udata));
            check("user_update", 64'(user_upd), 64'(m_upd));
        end
    end

    // Update strobe counter
    always @(negedge clk) begin
        if (user_upd === 1'b1) pulses <= pulses + 1;
    end

    initial begin
        logic [63:0] out;
        logic        t;
        int          p0;
        rst_n = 1'b0; en = 1'b1; tck = 1'b0; tms = 1'b1; tdi = 1'b0; trst = 1'b0;
        user_in = 32'd0;
        tick(); tick(); tick();
        chk_on = 1'b1;
        check("reset_state", 64'(tap_state), 64'h0F);
        check("reset_tdo", 64'(tdo), 64'h0);
        check("reset_user_data", 64'(user_out), 64'h0);
        check("reset_update", 64'(user_upd), 64'h0);
        rst_n = 1'b1; tick();

        for (int i = 0; i < 5; i++) jclk(1'b1, 1'b0, t);
        check("tlr_after_5_tms", 64'(tap_state), 64'h0F);
        jclk(1'b0, 1'b0, t);
        check("rti", 64'(tap_state), 64'h0C);

        scan(1'b0, 32, 64'd0, out);
        check("idcode_stream", 64'(out[31:0]), 64'h1000_0001);

        scan(1'b1, 4, 64'hF, out);
        check("ir_capture_bits", 64'(out[1:0]), 64'h1);
        scan(1'b0, 5, 64'b01101, out);
        check("bypass_all_ones", 64'(out[4:0]), 64'b11010);

        user_in = 32'hDEAD_BEEF;
        scan(1'b1, 4, 64'h8, out);
        p0 = pulses;
        scan(1'b0, 32, 64'h1234_5678, out);
        check("user_capture_stream", 64'(out[31:0]), 64'hDEAD_BEEF);
        check("user_data_after_upd", 64'(user_out), 64'h1234_5678);
        check("model_user_data", 64'(m_udata), 64'h1234_5678);
        check("user_update_pulses", 64'(pulses - p0), 64'd1);

        p0 = pulses;
        jclk(1'b1, 1'b0, t);
        jclk(1'b0, 1'b0, t);
        jclk(1'b0, 1'b0, t);
        jclk(1'b0, 1'b1, t);
        jclk(1'b0, 1'b1, t);
        check("mid_shift_state", 64'(tap_state), 64'h02);
        trst = 1'b1; tick();
        check("trst_state", 64'(tap_state), 64'h0F);
        trst = 1'b0; tick();
        check("trst_user_data_kept", 64'(user_out), 64'h1234_5678);
        check("trst_no_pulse", 64'(pulses - p0), 64'd0);
        jclk(1'b0, 1'b0, t);
        scan(1'b0, 32, 64'd0, out);
        check("trst_ir_idcode", 64'(out[31:0]), 64'h1000_0001);

        en = 1'b0;
        for (int i = 0; i < 10; i++) jclk(1'b1, 1'b0, t);
        check("disabled_state", 64'(tap_state), 64'h0C);
        check("disabled_tdo", 64'(tdo), 64'h0);
        en = 1'b1; tick();

        scan(1'b1, 4, 64'h3, out);
        scan(1'b0, 5, 64'b01101, out);
        check("bypass_undefined_ir", 64'(out[4:0]), 64'b11010);

        tms = 1'b1; tck = 1'b1; trst = 1'b1; tick();
        check("trst_beats_rise", 64'(tap_state), 64'h0F);
        trst = 1'b0; tick();
        tck = 1'b0; tick(); tick();
        jclk(1'b0, 1'b0, t);
        check("rti_after_trst", 64'(tap_state), 64'h0C);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
